// File: rtl/key_event_encoder_if.sv
// Key event bus between the push-button front end and the game logic.
// master = encoder side (takes raw buttons, drives coded events); slave = consumer side.
interface key_event_encoder_if #(
  parameter int N_KEYS = 12
);
  logic [N_KEYS-1:0] keypad_in;
  logic [3:0]        scan_out;
  logic              key_valid;
  logic              multi_press;
  logic              key_held;

  modport master (
    input  keypad_in,
    output scan_out,
    output key_valid,
    output multi_press,
    output key_held
  );

  modport slave (
    output keypad_in,
    input  scan_out,
    input  key_valid,
    input  multi_press,
    input  key_held
  );
endinterface

// File: rtl/key_event_encoder.sv
// Button front end: 2-flop sync, per-key debounce, press-edge detect and a
// lockout FSM that emits one coded single-cycle event per physical press.
module key_event_encoder #(
  parameter int N_KEYS          = 12,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 15
) (
  input logic            clk,
  input logic            rst,
  key_event_encoder_if.master kif
);

  typedef enum logic [1:0] {IDLE, EMIT, WAIT_REL} state_t;

  logic [N_KEYS-1:0] sync_p0;
  logic [N_KEYS-1:0] sync_p1;
  logic [N_KEYS-1:0] stable_p2;
  logic [N_KEYS-1:0] stable_d_p3;
  logic [N_KEYS-1:0] press_p3;
  logic [CNT_W-1:0]  cnt_p2 [N_KEYS];

  state_t     state, state_nxt;
  logic [3:0] code_q, code_nxt;

  function automatic logic [3:0] lowest_code(input logic [N_KEYS-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (v[i]) c = 4'(i + 1);
    end
    return c;
  endfunction

  function automatic logic more_than_one(input logic [N_KEYS-1:0] v);
    return (v & (v - 1'b1)) != '0;
  endfunction

  // Stage 0/1: two-flop synchroniser on the raw buttons
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= kif.keypad_in;
      sync_p1 <= sync_p0;
    end
  end

  // Stage 2: a mismatch must persist DEBOUNCE_CYCLES cycles before stable flips
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_p2 <= '0;
      for (int i = 0; i < N_KEYS; i++) cnt_p2[i] <= '0;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (sync_p1[i] == stable_p2[i]) begin
          cnt_p2[i] <= '0;
        end else if (cnt_p2[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable_p2[i] <= ~stable_p2[i];
          cnt_p2[i]    <= '0;
        end else begin
          cnt_p2[i] <= cnt_p2[i] + 1'b1;
        end
      end
    end
  end

  // Stage 3: registered rising-edge detect; releases produce nothing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_d_p3 <= '0;
      press_p3    <= '0;
    end else begin
      stable_d_p3 <= stable_p2;
      press_p3    <= stable_p2 & ~stable_d_p3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      code_q <= 4'd0;
    end else begin
      state  <= state_nxt;
      code_q <= code_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    code_nxt  = code_q;
    unique case (state)
      IDLE: begin
        if (press_p3 != '0) begin
          code_nxt  = lowest_code(press_p3);
          state_nxt = EMIT;
        end
      end
      EMIT:     state_nxt = WAIT_REL;
      WAIT_REL: if (stable_p2 == '0) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Stage 4: registered outputs; multi_press samples the levels seen during EMIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kif.scan_out    <= 4'd0;
      kif.key_valid   <= 1'b0;
      kif.multi_press <= 1'b0;
      kif.key_held    <= 1'b0;
    end else begin
      kif.scan_out    <= (state == EMIT) ? code_q : 4'd0;
      kif.key_valid   <= (state == EMIT);
      kif.multi_press <= (state == EMIT) && more_than_one(stable_p2);
      kif.key_held    <= (state == WAIT_REL);
    end
  end

endmodule

// File: tb/tb_key_event_encoder.sv
// Bench for key_event_encoder: directed scenarios plus random button traffic,
// compared every cycle against an event-timing reference model.
module tb_key_event_encoder;
  localparam int N = 12;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  key_event_encoder_if #(.N_KEYS(N)) kif ();

  key_event_encoder #(.N_KEYS(N), .DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif)
  );

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [N-1:0] rawh [0:D+1];
  logic [N-1:0] m_stable;
  int           n;
  bit           locked, have_ev;
  int           ev_edge;
  logic [3:0]   ev_code;
  logic         ev_multi;
  logic         exp_valid, exp_multi, exp_held;
  logic [3:0]   exp_code;

  int           strobes;
  logic [3:0]   last_code;
  logic         last_multi;
  int           last_edge;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k <= D + 1; k++) rawh[k] = '0;
    m_stable = '0;
    locked = 0; have_ev = 0; ev_edge = 0; ev_code = 0; ev_multi = 0;
    exp_valid = 0; exp_code = 0; exp_multi = 0; exp_held = 0;
  endtask

  // Stable flips when the synchronised samples of the last D cycles all
  // disagree with it; an event surfaces 3 edges after the flip edge and the
  // lockout holds until stable is all-zero at some edge >= event+4.
  task automatic model_edge(input logic [N-1:0] kp);
    logic [N-1:0] prev, rise;
    bit all_diff;
    n++;
    exp_held = 0;
    if (locked && n >= ev_edge + 4) begin
      exp_held = 1;
      if (m_stable == '0) locked = 0;
    end
    for (int k = D + 1; k >= 1; k--) rawh[k] = rawh[k-1];
    rawh[0] = kp;
    prev = m_stable;
    for (int i = 0; i < N; i++) begin
      all_diff = 1;
      for (int k = 2; k <= D + 1; k++) if (rawh[k][i] == prev[i]) all_diff = 0;
      if (all_diff) m_stable[i] = ~prev[i];
    end
    rise = m_stable & ~prev;
    if (!locked && rise != '0) begin
      locked = 1; have_ev = 1; ev_edge = n; ev_code = 0;
      for (int i = N - 1; i >= 0; i--) if (rise[i]) ev_code = 4'(i + 1);
    end
    if (have_ev && n == ev_edge + 2) ev_multi = ($countones(m_stable) > 1);
    exp_valid = have_ev && (n == ev_edge + 3);
    exp_code  = exp_valid ? ev_code : 4'd0;
    exp_multi = exp_valid && ev_multi;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".key_valid"},   8'(kif.key_valid),   8'(exp_valid));
    chk({tag, ".scan_out"},    8'(kif.scan_out),    8'(exp_code));
    chk({tag, ".multi_press"}, 8'(kif.multi_press), 8'(exp_multi));
    chk({tag, ".key_held"},    8'(kif.key_held),    8'(exp_held));
  endtask

  // one clock: drive at negedge, model at posedge, compare at next negedge
  task automatic tick(input logic [N-1:0] kp, input string tag);
    kif.keypad_in = kp;
    @(posedge clk);
    if (rst) model_edge(kp);
    @(negedge clk);
    check_outputs(tag);
    if (kif.key_valid === 1'b1) begin
      strobes++; last_code = kif.scan_out; last_multi = kif.multi_press; last_edge = n;
    end
  endtask

  task automatic hold(input logic [N-1:0] kp, input int cycles, input string tag);
    for (int c = 0; c < cycles; c++) tick(kp, tag);
  endtask

  int s0, step_edge;
  logic [N-1:0] kp;
  bit seen;

  initial begin
    kif.keypad_in = '0;
    model_reset();
    n = 0; strobes = 0; last_code = 0; last_multi = 0; last_edge = 0;
    hold('0, 3, "reset");
    @(negedge clk);
    rst = 1'b1;

    // single key b3
    s0 = strobes; step_edge = n + 1;
    hold(12'h004, 12, "b3");
    chk("b3.strobes", 8'(strobes - s0), 8'd1);
    chk("b3.code", 8'(last_code), 8'd3);
    chk("b3.latency", 8'(last_edge - step_edge), 8'd8);
    chk("b3.held", 8'(kif.key_held), 8'd1);
    hold('0, 10, "b3rel");
    chk("b3rel.strobes", 8'(strobes - s0), 8'd1);
    chk("b3rel.held", 8'(kif.key_held), 8'd0);

    // short glitch rejected, minimum-length pulse accepted
    s0 = strobes;
    hold(12'h001, 3, "glitch");
    hold('0, 12, "glitch");
    chk("glitch.strobes", 8'(strobes - s0), 8'd0);
    hold(12'h001, 4, "pulse");
    hold('0, 12, "pulse");
    chk("pulse.strobes", 8'(strobes - s0), 8'd1);
    chk("pulse.code", 8'(last_code), 8'd1);

    // two keys on the same edge
    s0 = strobes;
    hold(12'h210, 12, "dual");
    hold('0, 10, "dual");
    chk("dual.strobes", 8'(strobes - s0), 8'd1);
    chk("dual.code", 8'(last_code), 8'd5);
    chk("dual.multi", 8'(last_multi), 8'd1);

    // lockout while another key is held
    s0 = strobes;
    hold(12'h002, 10, "lock");
    hold(12'h802, 10, "lock");
    hold(12'h800, 10, "lock");
    chk("lock.strobes", 8'(strobes - s0), 8'd1);
    chk("lock.code", 8'(last_code), 8'd2);
    hold('0, 10, "lock");
    hold(12'h800, 12, "lock2");
    chk("lock2.strobes", 8'(strobes - s0), 8'd2);
    chk("lock2.code", 8'(last_code), 8'd12);
    chk("lock2.multi", 8'(last_multi), 8'd0);
    hold('0, 10, "lock2");

    // bouncy press on b7
    s0 = strobes;
    tick(12'h040, "bounce"); tick(12'h000, "bounce"); tick(12'h040, "bounce");
    tick(12'h040, "bounce"); tick(12'h000, "bounce");
    step_edge = n + 1;
    hold(12'h040, 14, "bounce");
    chk("bounce.strobes", 8'(strobes - s0), 8'd1);
    chk("bounce.code", 8'(last_code), 8'd7);
    chk("bounce.latency", 8'(last_edge - step_edge), 8'd8);
    hold('0, 10, "bounce");

    // reset during the emit cycle with b8 held
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick(12'h080, "rstemit");
      if (kif.key_valid === 1'b1) seen = 1;
    end
    chk("rstemit.reached", 8'(seen), 8'd1);
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs("rstemit.async");
    hold(12'h080, 3, "rstemit.inrst");
    rst = 1'b1;
    s0 = strobes; step_edge = n + 1;
    hold(12'h080, 12, "rstemit.after");
    chk("rstemit.strobes", 8'(strobes - s0), 8'd1);
    chk("rstemit.code", 8'(last_code), 8'd8);
    chk("rstemit.latency", 8'(last_edge - step_edge), 8'd8);
    hold('0, 10, "rstemit.rel");

    // random traffic: sparse key sets held for random durations
    for (int seg = 0; seg < 80; seg++) begin
      kp = '0;
      if ($urandom_range(0, 3) != 0) kp[$urandom_range(0, N - 1)] = 1'b1;
      if ($urandom_range(0, 3) == 0) kp[$urandom_range(0, N - 1)] = 1'b1;
      hold(kp, $urandom_range(1, 10), "rand");
    end
    hold('0, 15, "rand.tail");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
